// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-bit multiply/divide unit for the EX stage.
//
// Computes MULTU/MULT/DIVU/DIV over 33 clocks (32 iterations plus one sign-fix
// cycle) and holds the results in the architectural HI/LO registers. MTHI/MTLO
// writes go through hi_we/lo_we and are honoured only while idle.
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-high reset
//   start  in   request an operation (accepted only when idle and not flushed)
//   op     in   00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a, b   in   operands (multiplicand/dividend, multiplier/divisor)
//   flush  in   synchronous abort of the in-flight operation
//   hi_we  in   MTHI write enable
//   lo_we  in   MTLO write enable
//   wdata  in   MTHI/MTLO data
//   busy   out  operation in flight
//   done   out  one-cycle pulse when HI/LO take a result
//   hi     out  HI register (product[63:32] or remainder)
//   lo     out  LO register (product[31:0] or quotient)
//
// Build option: define MULDIV_DIVIDE_EN to build the divider. Without it,
// starts with op[1]=1 are ignored and only multiplies are supported.

module mult_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits shifting into quotient}.
  logic [63:0] acc_q, acc_d;
  // Multiplicand magnitude, or divisor magnitude.
  logic [31:0] opnd_q, opnd_d;
  logic        neg_q, neg_d;
  logic        done_q, done_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic        accept;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [63:0] prod_fix;

  assign mag_a = (op[0] && a[31]) ? -a : a;
  assign mag_b = (op[0] && b[31]) ? -b : b;

  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign prod_fix = neg_q ? -acc_q : acc_q;

`ifdef MULDIV_DIVIDE_EN
  logic        is_div_q, is_div_d;
  logic        rem_neg_q, rem_neg_d;
  logic        div0_q, div0_d;
  logic [32:0] rem_shift, rem_diff;
  logic [31:0] quot_fix, rem_fix;

  assign accept    = (state_q == IDLE) && start && !flush;
  assign rem_shift = {acc_q[63:32], acc_q[31]};
  assign rem_diff  = rem_shift - {1'b0, opnd_q};
  assign quot_fix  = div0_q ? 32'hFFFF_FFFF : (neg_q ? -acc_q[31:0] : acc_q[31:0]);
  // Remainder follows the dividend's sign; for divide-by-zero this restores a.
  assign rem_fix   = rem_neg_q ? -acc_q[63:32] : acc_q[63:32];
`else
  assign accept = (state_q == IDLE) && start && !flush && !op[1];
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    neg_d   = neg_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MULDIV_DIVIDE_EN
    is_div_d  = is_div_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;
`endif
    case (state_q)
      IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (accept) begin
          state_d = CALC;
          cnt_d   = 5'd31;
          neg_d   = op[0] & (a[31] ^ b[31]);
`ifdef MULDIV_DIVIDE_EN
          is_div_d  = op[1];
          rem_neg_d = op[0] & a[31];
          div0_d    = (b == 32'd0);
          opnd_d    = op[1] ? mag_b : mag_a;
          acc_d     = {32'd0, op[1] ? mag_a : mag_b};
`else
          opnd_d = mag_a;
          acc_d  = {32'd0, mag_b};
`endif
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
`ifdef MULDIV_DIVIDE_EN
          if (is_div_q) begin
            // Restoring step: keep the subtraction only if it did not borrow.
            acc_d = rem_diff[32] ? {rem_shift[31:0], acc_q[30:0], 1'b0}
                                 : {rem_diff[31:0], acc_q[30:0], 1'b1};
          end else begin
            acc_d = {mul_sum, acc_q[31:1]};
          end
`else
          acc_d = {mul_sum, acc_q[31:1]};
`endif
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd0) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!flush) begin
          done_d = 1'b1;
`ifdef MULDIV_DIVIDE_EN
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end else begin
            hi_d = prod_fix[63:32];
            lo_d = prod_fix[31:0];
          end
`else
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      acc_q   <= 64'd0;
      opnd_q  <= 32'd0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

`ifdef MULDIV_DIVIDE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_div_q  <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      is_div_q  <= is_div_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
    end
  end
`endif

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
